// File: rtl/pmult_pipe_hs.sv
// pmult_pipe_hs: four-stage WIDTH x WIDTH shift-and-add multiplier with valid/ready on both sides.
// Define PMULT_SIGNED_EN to add the sgn port and two's-complement operation.
module pmult_pipe_hs #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [TAG_W-1:0]   tag_in,
`ifdef PMULT_SIGNED_EN
  input  logic               sgn,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic [TAG_W-1:0]   tag_out,
  output logic               busy
);
  localparam int PW = 2*WIDTH;

  logic v1, v2, v3, v4;
  logic en1, en2, en3, en4;

  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic [WIDTH-1:0] a1, b1;
  logic [TAG_W-1:0] tag1, tag2, tag3;
  logic [PW-1:0]    pp_c [WIDTH];
  logic [PW-1:0]    pp2  [WIDTH];
  logic [PW-1:0]    sum_c, sum3;

  // A stage may load whenever it is empty or its successor is moving, so bubbles collapse.
  assign en4       = ~v4 | out_ready;
  assign en3       = ~v3 | en4;
  assign en2       = ~v2 | en3;
  assign en1       = ~v1 | en2;
  assign in_ready  = en1 & ~rst;
  assign out_valid = v4;
  assign busy      = v1 | v2 | v3 | v4;

`ifdef PMULT_SIGNED_EN
  localparam logic [WIDTH-1:0] ZERO_W = '0;
  localparam logic [PW-1:0]    ZERO_P = '0;
  logic neg_c, neg1, neg2, neg3;

  // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is still the correct unsigned magnitude.
  always_comb begin
    a_mag_c = (sgn & a[WIDTH-1]) ? (ZERO_W - a) : a;
    b_mag_c = (sgn & b[WIDTH-1]) ? (ZERO_W - b) : b;
    neg_c   = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (en1) neg1 <= neg_c;
    if (en2) neg2 <= neg1;
    if (en3) neg3 <= neg2;
  end
`else
  assign a_mag_c = a;
  assign b_mag_c = b;
`endif

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      pp_c[i] = {{WIDTH{1'b0}}, b1 & {WIDTH{a1[i]}}} << i;
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_c = sum_c + pp2[i];
    end
  end

  // Datapath registers of stages 1..3 carry no reset; only the valid flags qualify them.
  always_ff @(posedge clk) begin
    if (en1) begin
      a1   <= a_mag_c;
      b1   <= b_mag_c;
      tag1 <= tag_in;
    end
    if (en2) begin
      pp2  <= pp_c;
      tag2 <= tag1;
    end
    if (en3) begin
      sum3 <= sum_c;
      tag3 <= tag2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      v4      <= 1'b0;
      p       <= '0;
      tag_out <= '0;
    end else begin
      if (en1) v1 <= in_valid;
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
      if (en4) begin
        v4      <= v3;
        tag_out <= tag3;
`ifdef PMULT_SIGNED_EN
        p       <= neg3 ? (ZERO_P - sum3) : sum3;
`else
        p       <= sum3;
`endif
      end
    end
  end

endmodule
